uart_tx_serializer: RTL and testbench
=====================================

Name: uart_tx_serializer

Overview:
Serial-side transmit engine for the UART NIC. It accepts one word per handshake from the controller's tx ring-buffer drain logic and emits an 8N1-style frame on the tx line: start bit, WORD_SIZE data bits LSB first, optional parity bit, then STOP_BITS stop bits. The baud timing is derived from the system clock. It is the counterpart of the receiver, and its frame format must match it bit-for-bit.

Parameters:
WORD_SIZE, 8, data bits per frame (same value as uart_parameters.WORD_SIZE)
CLKS_PER_BIT, 16, clk cycles per serial bit; legal values are 2 or greater
STOP_BITS, 1, number of stop bits; legal values are 1 or 2
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; used only when UART_PARITY_EN is defined

Ports:
clk  in  1  system clock; all logic runs on the rising edge
rst  in  1  synchronous, active-high reset
data_send  in  WORD_SIZE  word to transmit; sampled only on an accept edge
tx_send_i  in  1  send request from the controller, normally a 1-cycle pulse
tx_avbl_i  out  1  high when the serializer is idle and able to accept a word
tx  out  1  serial line; idles high
tx_done_i  out  1  1-cycle pulse when the last stop bit of a frame completes
tx_ovr_i  out  1  1-cycle pulse when tx_send_i arrives while busy; that word is dropped

Behaviour:
- Reset values: tx=1, tx_avbl_i=1, tx_done_i=0, tx_ovr_i=0, state=IDLE, all counters 0.
- Reset during a frame: at the next edge the frame is truncated, tx=1 and the state is IDLE. No tx_done_i pulse is produced.
- FSM states are IDLE, START, DATA, PARITY (only with UART_PARITY_EN) and STOP.
- tx_avbl_i is 1 if and only if state==IDLE. It is decoded from the registered state, with no combinational path from tx_send_i.
- Accept: on an edge where state==IDLE and tx_send_i=1:
  - latch data_send into the shift register;
  - tx<=0, state<=START, baud_cnt<=0.
  - tx_avbl_i reads 0 from the next cycle onward.
- Bit timing: baud_cnt counts 0 to CLKS_PER_BIT-1. Each bit is held for exactly CLKS_PER_BIT cycles. When baud_cnt==CLKS_PER_BIT-1 the machine advances to the next bit.
- START holds tx=0 for one bit time, then goes to DATA with bit_idx=0.
- DATA drives tx=shift[0] and shifts right at each bit boundary.
  - After bit_idx==WORD_SIZE-1 completes, go to PARITY or STOP.
  - bit_idx is $clog2(WORD_SIZE) bits wide.
- STOP drives tx=1 for STOP_BITS bit times, tracked with a stop counter.
  - At the end of the final stop bit: tx_done_i=1 for that one cycle and state<=IDLE.
- Frame length from the accept edge to the return to IDLE is (1+WORD_SIZE+P+STOP_BITS)*CLKS_PER_BIT cycles, where P=1 with parity and 0 without.
- Back-to-back frames: a request on the first IDLE cycle is accepted. This gives a minimum inter-frame gap of stop bits plus 1 clk of tx=1.
- Request while busy (state!=IDLE and tx_send_i=1):
  - tx_ovr_i=1 for one cycle;
  - the request is ignored and the current frame is unaffected.
- tx_send_i held high across several IDLE cycles counts as only one accept; the serializer leaves IDLE on the accept edge.
- Widths: baud_cnt is $clog2(CLKS_PER_BIT) bits and wraps to 0 at each bit boundary. No counter is ever allowed to overflow silently.

Optional Feature:
UART_PARITY_EN:
- Defined: the PARITY state is inserted after DATA for one bit time.
  - tx = ^data, XOR-ed with PARITY_ODD, computed from the word latched at accept.
- Undefined: the PARITY state, the parity register and the parity logic are absent. DATA goes directly to STOP and PARITY_ODD is ignored.

Decomposition:
- Shared package uart_pkg:
  - state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - default CLKS_PER_BIT;
  - TX_IDLE_LEVEL=1'b1.
- WORD_SIZE remains sourced from uart_parameters.
- One sub-module: uart_baud_tick, a counter that emits a bit-boundary tick every CLKS_PER_BIT cycles and clears on rst or on accept. The receiver reuses it.

Test Plan:
1. WORD_SIZE=8, CLKS_PER_BIT=4, no parity, send 0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 clks. tx_done_i pulses once, 40 clks after accept. tx_avbl_i is low for exactly 40 clks.
2. UART_PARITY_EN, PARITY_ODD=0, send 0xA5 -> parity bit 0 after bit 7. Same config with PARITY_ODD=1 and send 0x01 -> parity bit 0. Frame is 44 clks.
3. Send 0x3C, then pulse tx_send_i with 0xFF at clk 10 of the frame -> tx_ovr_i pulses at that cycle and the 0x3C frame is unchanged. Then send 0xFF on the first IDLE cycle -> exactly 1 extra idle-high clk between frames.
4. STOP_BITS=2, send 0x00 -> stop held high for 8 clks. tx_done_i is at the last stop clk.
5. Assert rst at clk 15 of a 0x55 frame -> tx=1, tx_avbl_i=1 and no tx_done_i at the next edge. A following send of 0x55 produces a clean full frame.
6. Hold tx_send_i high for 3 IDLE clks with 0x81 -> exactly one frame is sent, and tx_ovr_i pulses for the 2 busy-cycle requests.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default baud divisor, idle line level.
// Used by both the transmit serializer and the receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int   CLKS_PER_BIT_DEFAULT = 16;
    localparam logic TX_IDLE_LEVEL        = 1'b1;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-boundary tick generator: baud_cnt runs 0..CLKS_PER_BIT-1 and tick marks the last
// cycle of each bit. Cleared on rst or clear (frame accept); shared with the receiver.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] baud_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            baud_cnt <= '0;
        end else if (baud_cnt == CNT_LAST) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    assign tick = (baud_cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: start bit, WORD_SIZE data bits LSB first, optional parity, STOP_BITS stops.
// Parity bit is present only when UART_PARITY_EN is defined.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WORD_SIZE    = 8,
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] data_send,
    input  logic                 tx_send_i,
    output logic                 tx_avbl_i,
    output logic                 tx,
    output logic                 tx_done_i,
    output logic                 tx_ovr_i
);

    localparam int             IDX_W     = $clog2(WORD_SIZE);
    localparam logic [IDX_W-1:0] BIT_LAST = IDX_W'(WORD_SIZE - 1);
    localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_param_check
        $error("uart_tx_serializer: illegal parameter value");
    end

    uart_state_t          state;
    logic [WORD_SIZE-1:0] shift;
    logic [IDX_W-1:0]     bit_idx;
    logic                 stop_cnt;
    logic                 accept;
    logic                 tick;
`ifdef UART_PARITY_EN
    logic                 par_bit;
`endif

    assign accept    = (state == IDLE) && tx_send_i;
    assign tx_avbl_i = (state == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .clear(accept),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= TX_IDLE_LEVEL;
            tx_done_i <= 1'b0;
            tx_ovr_i  <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
`ifdef UART_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            tx_done_i <= 1'b0;
            tx_ovr_i  <= (state != IDLE) && tx_send_i;
            case (state)
                IDLE: begin
                    tx <= TX_IDLE_LEVEL;
                    if (tx_send_i) begin
                        shift    <= data_send;
                        tx       <= 1'b0;
                        state    <= START;
                        bit_idx  <= '0;
                        stop_cnt <= 1'b0;
`ifdef UART_PARITY_EN
                        par_bit  <= (^data_send) ^ 1'(PARITY_ODD);
`endif
                    end
                end
                START: begin
                    if (tick) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx == BIT_LAST) begin
`ifdef UART_PARITY_EN
                            state    <= PARITY;
                            tx       <= par_bit;
`else
                            state    <= STOP;
                            tx       <= TX_IDLE_LEVEL;
                            stop_cnt <= 1'b0;
`endif
                        end else begin
                            // tx is registered, so present the next bit as we shift
                            bit_idx <= bit_idx + 1'b1;
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef UART_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state    <= STOP;
                        tx       <= TX_IDLE_LEVEL;
                        stop_cnt <= 1'b0;
                    end
                end
`endif
                STOP: begin
                    tx <= TX_IDLE_LEVEL;
                    if (tick) begin
                        if (stop_cnt == STOP_LAST) begin
                            tx_done_i <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= TX_IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (1 and 2 stop bits, even/odd parity).
// Expected per-clock tx levels are queued at send time and popped as the frame is sampled.
module tb_uart_tx_serializer;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] send_v = '0;
    logic [7:0] data_v [2];
    logic [1:0] tx_v, avbl_v, done_v, ovr_v;

    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];
    logic ovr_exp;

    always #5 clk = ~clk;

    uart_tx_serializer #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .data_send(data_v[0]), .tx_send_i(send_v[0]),
        .tx_avbl_i(avbl_v[0]), .tx(tx_v[0]), .tx_done_i(done_v[0]), .tx_ovr_i(ovr_v[0])
    );

    uart_tx_serializer #(.WORD_SIZE(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(1)) dut_b (
        .clk(clk), .rst(rst), .data_send(data_v[1]), .tx_send_i(send_v[1]),
        .tx_avbl_i(avbl_v[1]), .tx(tx_v[1]), .tx_done_i(done_v[1]), .tx_ovr_i(ovr_v[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int stop_bits_of(input int u);
        return (u == 1) ? 2 : 1;
    endfunction

    function automatic logic parity_odd_of(input int u);
        return (u == 1) ? 1'b1 : 1'b0;
    endfunction

    task automatic push_bit(input logic lvl);
        for (int c = 0; c < CPB; c++) exp_q.push_back(lvl);
    endtask

    task automatic push_frame(input int u, input logic [7:0] w);
        push_bit(1'b0);
        for (int i = 0; i < 8; i++) push_bit(w[i]);
`ifdef UART_PARITY_EN
        push_bit((^w) ^ parity_odd_of(u));
`endif
        for (int s = 0; s < stop_bits_of(u); s++) push_bit(1'b1);
    endtask

    // Starts at a negedge with the DUT idle; the accept happens on the next rising edge.
    // Returns at the negedge after the frame's last edge (done visible, DUT idle).
    task automatic run_frame(input int u, input logic [7:0] w, input int inject_at,
                             input int rst_at, input int hold_n);
        int   len;
        logic e;
        push_frame(u, w);
        len        = exp_q.size();
        data_v[u]  = w;
        send_v[u]  = 1'b1;
        ovr_exp    = 1'b0;
        @(negedge clk);
        for (int j = 1; j <= len; j++) begin
            e = exp_q.pop_front();
            chk("tx_level", tx_v[u], e);
            chk("avbl_busy", avbl_v[u], 1'b0);
            chk("done_early", done_v[u], 1'b0);
            chk("ovr", ovr_v[u], ovr_exp);
            if (j == rst_at) begin
                rst       = 1'b1;
                send_v[u] = 1'b0;
                @(negedge clk);
                chk("rst_tx", tx_v[u], 1'b1);
                chk("rst_avbl", avbl_v[u], 1'b1);
                chk("rst_no_done", done_v[u], 1'b0);
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            send_v[u] = (j < hold_n) || (j == inject_at);
            if (j == inject_at) data_v[u] = 8'hFF;
            ovr_exp = send_v[u];
            @(negedge clk);
        end
        chk("done_pulse", done_v[u], 1'b1);
        chk("avbl_end", avbl_v[u], 1'b1);
        chk("tx_gap", tx_v[u], 1'b1);
        chk("ovr_end", ovr_v[u], ovr_exp);
        send_v[u] = 1'b0;
    endtask

    task automatic idle(input int u, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("idle_tx", tx_v[u], 1'b1);
            chk("idle_avbl", avbl_v[u], 1'b1);
            chk("idle_done", done_v[u], 1'b0);
            chk("idle_ovr", ovr_v[u], 1'b0);
        end
    endtask

    initial begin
        data_v[0] = '0;
        data_v[1] = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_tx", tx_v[u], 1'b1);
            chk("reset_avbl", avbl_v[u], 1'b1);
            chk("reset_done", done_v[u], 1'b0);
            chk("reset_ovr", ovr_v[u], 1'b0);
        end
        rst = 1'b0;
        idle(0, 2);

        run_frame(0, 8'hA5, 0, 0, 1);
        idle(0, 3);

        // overrun mid-frame, then back-to-back send on the first idle cycle
        run_frame(0, 8'h3C, 10, 0, 1);
        run_frame(0, 8'hFF, 0, 0, 1);
        idle(0, 3);

        run_frame(1, 8'h00, 0, 0, 1);
        idle(1, 3);
        run_frame(1, 8'h01, 0, 0, 1);
        idle(1, 2);
        run_frame(1, 8'hC3, 0, 0, 1);
        idle(1, 2);

        run_frame(0, 8'h55, 0, 15, 1);
        idle(0, 2);
        run_frame(0, 8'h55, 0, 0, 1);
        idle(0, 2);

        // request held three cycles: one frame, two overrun pulses
        run_frame(0, 8'h81, 0, 0, 3);
        idle(0, 12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
